// File: rtl/ct_spsram_1024x32_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM controller:
// FSM state encodings, requester ids and default geometry.
package ct_spsram_1024x32_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH = 10;
    localparam int unsigned SRAM_DATA_WIDTH = 32;
    localparam int unsigned SRAM_DEPTH      = 1024;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_INIT = 2'b01,
        ST_IDLE = 2'b10
    } state_t;

    // Requester ids, also the encoding of the last-granted pointer
    localparam logic RQ0 = 1'b0;
    localparam logic RQ1 = 1'b1;

endpackage

// File: rtl/ct_spsram_ctrl_rr_arb.sv
// Two-way round-robin arbiter with a last-granted pointer that resets
// to requester 1, so requester 0 wins the first conflict.
module ct_spsram_ctrl_rr_arb
    import ct_spsram_1024x32_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    input  logic [1:0] vld,
    input  logic       enable,
    input  logic       update,
    output logic [1:0] grnt
);

    logic last;

    // One-hot grant: single requester wins outright, a conflict goes to the one not granted last
    always_comb begin
        grnt = 2'b00;
        if (enable) begin
            case (vld)
                2'b01:   grnt = 2'b01;
                2'b10:   grnt = 2'b10;
                2'b11:   grnt = (last == RQ1) ? 2'b01 : 2'b10;
                default: grnt = 2'b00;
            endcase
        end
    end

    // Pointer moves only when a grant is actually issued
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            last <= RQ1;
        end else if (update && (grnt != 2'b00)) begin
            last <= grnt[1];
        end
    end

endmodule

// File: rtl/ct_spsram_1024x32_ctrl.sv
// Shares one ct_spsram_1024x32 macro between two requesters.
// Optional build macro CT_SPSRAM_CTRL_INIT_EN: zero-fill the whole array
// after reset before any traffic is granted.
module ct_spsram_1024x32_ctrl
    import ct_spsram_1024x32_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = SRAM_DEPTH
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    rq0_vld,
    input  logic                    rq0_wr,
    input  logic [ADDR_WIDTH-1:0]   rq0_addr,
    input  logic [DATA_WIDTH-1:0]   rq0_wdata,
    input  logic [DATA_WIDTH/8-1:0] rq0_bmask,
    input  logic                    rq1_vld,
    input  logic                    rq1_wr,
    input  logic [ADDR_WIDTH-1:0]   rq1_addr,
    input  logic [DATA_WIDTH-1:0]   rq1_wdata,
    input  logic [DATA_WIDTH/8-1:0] rq1_bmask,
    output logic                    rq0_grnt,
    output logic                    rq1_grnt,
    output logic                    rq0_rvld,
    output logic                    rq1_rvld,
    output logic [DATA_WIDTH-1:0]   rq0_rdata,
    output logic [DATA_WIDTH-1:0]   rq1_rdata,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q,
    output logic                    init_done
);

    localparam int unsigned BMASK_WIDTH = DATA_WIDTH / 8;

    // Geometry sanity checks at elaboration
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_WIDTH");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

    state_t                  state;
    state_t                  state_next;
    logic                    arb_en;
    logic [1:0]              grnt;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [BMASK_WIDTH-1:0]  sel_bmask;
    logic [DATA_WIDTH-1:0]   sel_wen_c;
    logic                    rd_pending;
    logic                    rd_id;

    // Arbitration is only open in IDLE with reset released
    assign arb_en = cpurst_b && (state == ST_IDLE);

    ct_spsram_ctrl_rr_arb u_arb (
        .clk    (forever_cpuclk),
        .rst_b  (cpurst_b),
        .vld    ({rq1_vld, rq0_vld}),
        .enable (arb_en),
        .update (arb_en),
        .grnt   (grnt)
    );

    assign rq0_grnt = grnt[0];
    assign rq1_grnt = grnt[1];

    // Mux the granted requester's payload
    always_comb begin
        if (grnt[1]) begin
            sel_wr    = rq1_wr;
            sel_addr  = rq1_addr;
            sel_wdata = rq1_wdata;
            sel_bmask = rq1_bmask;
        end else begin
            sel_wr    = rq0_wr;
            sel_addr  = rq0_addr;
            sel_wdata = rq0_wdata;
            sel_bmask = rq0_bmask;
        end
    end

    // Byte enables expand to active-low per-bit write enables
    for (genvar b = 0; b < BMASK_WIDTH; b++) begin : g_wen
        assign sel_wen_c[b*8 +: 8] = {8{~sel_bmask[b]}};
    end

`ifdef CT_SPSRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_last;

    assign init_last = (init_cnt == ADDR_WIDTH'(DEPTH - 1));

    // Zero-fill address counter; held at 0 outside INIT so a restart begins at 0
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b || (state != ST_INIT)) begin
            init_cnt <= '0;
        end else begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
        end
    end
`endif

    // FSM state register
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and macro pins; everything idles while reset is low
    always_comb begin
        state_next = state;
        sram_cen   = 1'b1;
        sram_gwen  = 1'b1;
        sram_wen   = '1;
        sram_a     = '0;
        sram_d     = '0;
        if (cpurst_b) begin
            case (state)
                ST_BOOT: begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
                    state_next = ST_INIT;
`else
                    state_next = ST_IDLE;
`endif
                end
                ST_INIT: begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = init_cnt;
                    if (init_last) begin
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
                ST_IDLE: begin
                    if (grnt != 2'b00) begin
                        sram_a = sel_addr;
                        if (!sel_wr) begin
                            sram_cen = 1'b0;
                        end else if (sel_bmask != '0) begin
                            sram_cen  = 1'b0;
                            sram_gwen = 1'b0;
                            sram_wen  = sel_wen_c;
                            sram_d    = sel_wdata;
                        end
                    end
                end
                default: state_next = ST_BOOT;
            endcase
        end
    end

    // Ready flag tracks entry into IDLE
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            init_done <= 1'b0;
        end else begin
            init_done <= (state_next == ST_IDLE);
        end
    end

    // Remember which requester owns the read data arriving next cycle
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            rd_pending <= 1'b0;
            rd_id      <= RQ0;
        end else begin
            rd_pending <= (grnt != 2'b00) && !sel_wr;
            rd_id      <= grnt[1];
        end
    end

    // Route macro read data to its owner; zero otherwise
    assign rq0_rvld  = cpurst_b && rd_pending && (rd_id == RQ0);
    assign rq1_rvld  = cpurst_b && rd_pending && (rd_id == RQ1);
    assign rq0_rdata = rq0_rvld ? sram_q : '0;
    assign rq1_rdata = rq1_rvld ? sram_q : '0;

endmodule
